// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between instruction fetch and load/store,
// one transaction at a time, with LS priority, anti-starvation and an ack watchdog.
module dmem_port_arbiter #(
   parameter int MAX_LS_BURST = 4,
   parameter int TIMEOUT_CYC  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [63:0] ls_addr,
   input  logic [63:0] ls_wdata,
   input  logic [7:0]  ls_wmask,
   output logic        ls_gnt,
   output logic        ls_rvalid,
   output logic [63:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_ack,
   input  logic [63:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_ls,
   output logic        bus_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] BURST_MAX = 4'(MAX_LS_BURST);
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

   logic [1:0] state;
   logic       owner_ls;
   logic [7:0] wait_cnt;
   logic [3:0] ls_burst;

   // LS wins ties unless it has already used its burst allowance while IF waited
   always_comb begin
      if_gnt = 1'b0;
      ls_gnt = 1'b0;
      if (state == ST_IDLE && !rst) begin
         if (ls_req && !(if_req && ls_burst == BURST_MAX))
            ls_gnt = 1'b1;
         else if (if_req)
            if_gnt = 1'b1;
      end
   end

   assign mem_req   = (state == ST_WAIT);
   assign if_rvalid = (state == ST_RESP) && !owner_ls;
   assign ls_rvalid = (state == ST_RESP) && owner_ls;
   assign stall_if  = if_req && !if_rvalid;
   assign stall_ls  = ls_req && !ls_rvalid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         owner_ls  <= 1'b0;
         wait_cnt  <= '0;
         ls_burst  <= '0;
         rdata     <= '0;
         bus_err   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
      end else begin
         if (!if_req || if_gnt)
            ls_burst <= '0;
         else if (ls_gnt && ls_burst != BURST_MAX)
            ls_burst <= ls_burst + 4'd1;

         case (state)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (ls_gnt) begin
                  owner_ls  <= 1'b1;
                  mem_we    <= ls_we;
                  mem_addr  <= ls_addr;
                  mem_wdata <= ls_wdata;
                  mem_wmask <= ls_wmask;
                  state     <= ST_WAIT;
               end else if (if_gnt) begin
                  owner_ls  <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= '0;
                  mem_wmask <= '0;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // an ack on the final permitted cycle still counts as a completion
               if (mem_ack) begin
                  rdata <= mem_we ? 64'd0 : mem_rdata;
                  state <= ST_RESP;
               end else if (wait_cnt == WAIT_LAST) begin
                  rdata   <= '0;
                  bus_err <= 1'b1;
                  state   <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_dmem_port_arbiter;

   localparam int MAXB = 4;
   localparam int TMO  = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = '0;
   logic        ls_req = 1'b0, ls_we = 1'b0;
   logic [63:0] ls_addr = '0, ls_wdata = '0;
   logic [7:0]  ls_wmask = '0;
   logic        mem_ack = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
   logic [63:0] rdata, mem_addr, mem_wdata;
   logic [7:0]  mem_wmask;
   logic        stall_if, stall_ls, bus_err;

   dmem_port_arbiter #(.MAX_LS_BURST(MAXB), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_ls(stall_ls), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model: at most one transaction in flight
   int          m_phase = 0;   // 0 none, 1 memory access outstanding, 2 response due
   bit          m_own_ls = 0, m_we = 0, m_err = 0;
   logic [63:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
   logic [7:0]  m_mask = '0;
   int          m_waited = 0;
   int          m_burst = 0;
   bit          e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv, e_mreq;

   bit if_pend = 0, ls_pend = 0, if_fin = 0, ls_fin = 0;
   int seq[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_check();
      e_if_gnt = 0;
      e_ls_gnt = 0;
      if (!rst && m_phase == 0) begin
         if (ls_req && !(if_req && m_burst >= MAXB)) e_ls_gnt = 1;
         else if (if_req) e_if_gnt = 1;
      end
      e_mreq  = (m_phase == 1);
      e_if_rv = (m_phase == 2) && !m_own_ls;
      e_ls_rv = (m_phase == 2) && m_own_ls;
      chk("m_if_gnt", if_gnt, e_if_gnt);
      chk("m_ls_gnt", ls_gnt, e_ls_gnt);
      chk("m_if_rvalid", if_rvalid, e_if_rv);
      chk("m_ls_rvalid", ls_rvalid, e_ls_rv);
      chk("m_mem_req", mem_req, e_mreq);
      chk("m_rdata", rdata, m_rdata);
      chk("m_bus_err", bus_err, m_err);
      chk("m_stall_if", stall_if, if_req && !e_if_rv);
      chk("m_stall_ls", stall_ls, ls_req && !e_ls_rv);
      if (e_mreq) begin
         chk("m_mem_we", mem_we, m_we);
         chk("m_mem_addr", mem_addr, m_addr);
         chk("m_mem_wmask", mem_wmask, m_mask);
         if (m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
      end
   endtask

   task automatic model_next();
      if (rst) begin
         m_phase = 0; m_burst = 0; m_rdata = '0; m_err = 0; m_own_ls = 0;
         if_pend = 0; ls_pend = 0; if_fin = 0; ls_fin = 0;
      end else begin
         if (e_if_rv) begin if_pend = 0; if_fin = 1; end
         if (e_ls_rv) begin ls_pend = 0; ls_fin = 1; end
         if (e_if_gnt) if_pend = 1;
         if (e_ls_gnt) ls_pend = 1;
         if (!if_req || e_if_gnt) m_burst = 0;
         else if (e_ls_gnt && m_burst < MAXB) m_burst++;
         if (m_phase == 0) begin
            if (e_ls_gnt) begin
               m_own_ls = 1; m_we = ls_we; m_addr = ls_addr; m_wdata = ls_wdata;
               m_mask = ls_wmask; m_waited = 0; m_phase = 1;
            end else if (e_if_gnt) begin
               m_own_ls = 0; m_we = 0; m_addr = if_addr; m_mask = '0;
               m_waited = 0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            m_waited++;
            if (mem_ack) begin
               m_rdata = m_we ? 64'd0 : mem_rdata;
               m_phase = 2;
            end else if (m_waited >= TMO) begin
               m_rdata = '0; m_err = 1; m_phase = 2;
            end
         end else begin
            m_phase = 0;
         end
      end
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic advance();
      model_check();
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   task automatic drive_random();
      if (if_fin) begin
         if_fin = 0;
         if_req = $urandom_range(1);
         if_addr = {$urandom, $urandom};
      end else if (if_req && if_pend && $urandom_range(7) == 0) begin
         if_req = 0;
      end else if (!if_req && !if_pend && $urandom_range(2) == 0) begin
         if_req = 1;
         if_addr = {$urandom, $urandom};
      end
      if (ls_fin || (!ls_req && !ls_pend && $urandom_range(2) == 0)) begin
         ls_fin = 0;
         ls_req = ls_fin ? 1'b0 : ($urandom_range(3) != 0);
         ls_we = $urandom_range(1);
         ls_addr = {$urandom, $urandom};
         ls_wdata = {$urandom, $urandom};
         ls_wmask = 8'($urandom);
      end else if (ls_req && ls_pend && $urandom_range(7) == 0) begin
         ls_req = 0;
      end
      mem_ack = (m_phase == 1) ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
      mem_rdata = {$urandom, $urandom};
      rst = ($urandom_range(399) == 0);
   endtask

   initial begin
      @(posedge clk);
      @(posedge clk);
      #1;
      tick();
      tick();
      settle();
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_bus_err", bus_err, 1'b0);
      chk("rst_mem_addr", mem_addr, 64'd0);
      advance();
      rst = 0;

      // single load, ack in the third WAIT cycle
      ls_req = 1; ls_we = 0; ls_addr = 64'h8000_0010;
      settle();
      chk("t1_gnt", ls_gnt, 1'b1);
      chk("t1_stall_n", stall_ls, 1'b1);
      advance();
      settle();
      chk("t1_mreq1", mem_req, 1'b1);
      chk("t1_maddr", mem_addr, 64'h8000_0010);
      advance();
      tick();
      mem_ack = 1; mem_rdata = 64'hDEAD;
      settle();
      chk("t1_mreq3", mem_req, 1'b1);
      chk("t1_stall3", stall_ls, 1'b1);
      advance();
      mem_ack = 0; mem_rdata = '0;
      settle();
      chk("t1_rvalid", ls_rvalid, 1'b1);
      chk("t1_rdata", rdata, 64'hDEAD);
      chk("t1_stall4", stall_ls, 1'b0);
      chk("t1_mreq4", mem_req, 1'b0);
      advance();
      ls_req = 0;
      settle();
      chk("t1_rvalid_off", ls_rvalid, 1'b0);
      advance();

      // store, ack in first WAIT cycle
      ls_req = 1; ls_we = 1; ls_addr = 64'h100; ls_wdata = 64'h55; ls_wmask = 8'h0F;
      settle();
      chk("t2_gnt", ls_gnt, 1'b1);
      advance();
      mem_ack = 1; mem_rdata = 64'hFFFF;
      settle();
      chk("t2_we", mem_we, 1'b1);
      chk("t2_mask", mem_wmask, 8'h0F);
      chk("t2_wdata", mem_wdata, 64'h55);
      advance();
      mem_ack = 0;
      settle();
      chk("t2_rvalid", ls_rvalid, 1'b1);
      chk("t2_rdata", rdata, 64'd0);
      advance();
      ls_req = 0; ls_we = 0;

      // spurious ack while idle
      mem_ack = 1; mem_rdata = 64'hBAD0;
      tick();
      mem_ack = 0;
      settle();
      chk("t6_ls_rv", ls_rvalid, 1'b0);
      chk("t6_if_rv", if_rvalid, 1'b0);
      chk("t6_rdata", rdata, 64'd0);
      advance();

      // both requesters held: four LS grants, then IF
      if_req = 1; if_addr = 64'h4000; ls_req = 1; ls_we = 0; ls_addr = 64'h2000;
      for (int c = 0; c < 60 && seq.size() < 10; c++) begin
         mem_ack = (m_phase == 1);
         mem_rdata = {$urandom, $urandom};
         settle();
         if (ls_gnt) seq.push_back(1);
         else if (if_gnt) seq.push_back(0);
         advance();
      end
      for (int i = 0; i < 10; i++)
         chk("t3_order", (i < seq.size()) ? seq[i] : 2, (i % 5 == 4) ? 0 : 1);
      if_req = 0; ls_req = 0;
      for (int c = 0; c < 4; c++) begin
         mem_ack = (m_phase == 1);
         tick();
      end
      mem_ack = 0;
      if_pend = 0; ls_pend = 0; if_fin = 0; ls_fin = 0;

      for (int c = 0; c < 3000; c++) begin
         drive_random();
         tick();
      end

      // reset during WAIT, late ack afterwards
      rst = 1; if_req = 0; ls_req = 0; mem_ack = 0;
      tick();
      rst = 0;
      ls_req = 1; ls_we = 0; ls_addr = 64'h3000;
      tick();
      tick();
      rst = 1;
      tick();
      rst = 0; ls_req = 0; mem_ack = 1; mem_rdata = 64'h7777;
      settle();
      chk("t5_mreq", mem_req, 1'b0);
      chk("t5_ls_rv", ls_rvalid, 1'b0);
      chk("t5_maddr", mem_addr, 64'd0);
      chk("t5_rdata", rdata, 64'd0);
      chk("t5_stall", stall_ls, 1'b0);
      advance();
      mem_ack = 0;
      settle();
      chk("t5_ls_rv2", ls_rvalid, 1'b0);
      chk("t5_mreq2", mem_req, 1'b0);
      advance();

      // fetch with no ack: watchdog abort after TMO WAIT cycles
      if_req = 1; if_addr = 64'h9000;
      settle();
      chk("t4_gnt", if_gnt, 1'b1);
      advance();
      begin
         int cnt = 0;
         settle();
         while (!if_rvalid && cnt < 300) begin
            advance();
            cnt++;
            settle();
         end
         chk("t4_wait_cycles", cnt, TMO);
      end
      chk("t4_rvalid", if_rvalid, 1'b1);
      chk("t4_rdata", rdata, 64'd0);
      chk("t4_bus_err", bus_err, 1'b1);
      advance();
      if_req = 0;
      ls_req = 1; ls_we = 0; ls_addr = 64'h50;
      tick();
      mem_ack = 1; mem_rdata = 64'h1234;
      tick();
      mem_ack = 0;
      settle();
      chk("t4_after_rd", rdata, 64'h1234);
      chk("t4_sticky", bus_err, 1'b1);
      advance();
      ls_req = 0;
      rst = 1;
      tick();
      rst = 0;
      settle();
      chk("t4_clr", bus_err, 1'b0);
      advance();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
